// File: rtl/poly_memory_control_mc.sv
// poly_memory_control_mc
// BRAM sequencer for the AMNS polynomial datapath. A load sequence streams
// A, B, M and M'_0 from one BRAM bank into the operand input registers. A
// store sequence writes NB_CH result polynomials back into the same bank.
// Each bank region holds LD_LEN operand words followed by ST_LEN result words.
//
// Ports:
//   clock_i          rising-edge clock
//   reset_i          asynchronous active-low reset
//   load_start_i     one-cycle pulse, starts a load sequence
//   store_start_i    one-cycle pulse, starts a store sequence
//   abort_i          ends any active sequence, no done pulse
//   bank_i           bank select, sampled when a start is accepted
//   BRAM_we_o        BRAM write enable
//   BRAM_addr_o      BRAM address
//   INPUT_reg_sel_o  operand selector (0=A, 1=B, 2=M, 3=M'_0)
//   INPUT_reg_en_o   input register enable, aligned to BRAM read data
//   RES_reg_shift_o  result shift-register advance
//   RES_ch_o         result channel currently being stored
//   busy_o           high whenever a sequence is active
//   load_done_o      one-cycle pulse at the end of a load
//   store_done_o     one-cycle pulse at the end of a store
module poly_memory_control_mc #(
  parameter  int WORD_WIDTH = 17,
  parameter  int N          = 5,
  parameter  int S          = 4,
  parameter  int LAT        = 2,
  parameter  int NB_CH      = 2,
  localparam int NS         = N * S,
  localparam int LD_LEN     = 3 * NS + N,
  localparam int ST_LEN     = NB_CH * NS,
  localparam int REGION     = LD_LEN + ST_LEN,
  localparam int ADDR_LEN   = $clog2(2 * REGION) + 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                load_start_i,
  input  logic                store_start_i,
  input  logic                abort_i,
  input  logic                bank_i,
  output logic                BRAM_we_o,
  output logic [ADDR_LEN-1:0] BRAM_addr_o,
  output logic [1:0]          INPUT_reg_sel_o,
  output logic                INPUT_reg_en_o,
  output logic                RES_reg_shift_o,
  output logic [1:0]          RES_ch_o,
  output logic                busy_o,
  output logic                load_done_o,
  output logic                store_done_o
);

  localparam int CNT_W = $clog2(REGION + 1);

  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    LD_LAST  = CNT_W'(LD_LEN - 1);
  localparam logic [CNT_W-1:0]    ST_LAST  = CNT_W'(ST_LEN - 1);
  localparam logic [CNT_W-1:0]    DR_LAST  = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0]    SEG_LAST = CNT_W'(NS - 1);
  localparam logic [CNT_W-1:0]    TAG1_LIM = CNT_W'(NS);
  localparam logic [CNT_W-1:0]    TAG2_LIM = CNT_W'(2 * NS);
  localparam logic [CNT_W-1:0]    TAG3_LIM = CNT_W'(3 * NS);
  localparam logic [ADDR_LEN-1:0] ADDR_ONE = ADDR_LEN'(1);
  localparam logic [ADDR_LEN-1:0] LD_B1    = ADDR_LEN'(REGION);
  localparam logic [ADDR_LEN-1:0] ST_B0    = ADDR_LEN'(LD_LEN);
  localparam logic [ADDR_LEN-1:0] ST_B1    = ADDR_LEN'(REGION + LD_LEN);

  if (LAT < 1 || LAT > 4 || NB_CH < 1 || NB_CH > 4 || WORD_WIDTH < 1) begin : g_param_check
    $error("poly_memory_control_mc: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, STORE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] seg;
  logic [1:0]       tag;
  logic             load_active;

  // Operand selector for the word being read in the current LOAD step.
  always_comb begin
    tag = 2'd3;
    if (cnt < TAG1_LIM)      tag = 2'd0;
    else if (cnt < TAG2_LIM) tag = 2'd1;
    else if (cnt < TAG3_LIM) tag = 2'd2;
  end

  assign load_active = (state == LOAD);

  // Address is a running pointer: the address following the last step of
  // LOAD (B0+LD_LEN) and of STORE (B0+REGION) is just one more increment.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state           <= IDLE;
      cnt             <= '0;
      seg             <= '0;
      BRAM_addr_o     <= '0;
      BRAM_we_o       <= 1'b0;
      RES_reg_shift_o <= 1'b0;
      RES_ch_o        <= '0;
      busy_o          <= 1'b0;
      load_done_o     <= 1'b0;
      store_done_o    <= 1'b0;
    end else begin
      load_done_o  <= 1'b0;
      store_done_o <= 1'b0;
      // Abort also covers IDLE: it matches the idle hold and drops any start.
      if (abort_i) begin
        state           <= IDLE;
        cnt             <= '0;
        seg             <= '0;
        BRAM_addr_o     <= '0;
        BRAM_we_o       <= 1'b0;
        RES_reg_shift_o <= 1'b0;
        RES_ch_o        <= '0;
        busy_o          <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt             <= '0;
            seg             <= '0;
            RES_ch_o        <= '0;
            if (load_start_i) begin
              state           <= LOAD;
              busy_o          <= 1'b1;
              BRAM_we_o       <= 1'b0;
              RES_reg_shift_o <= 1'b0;
              BRAM_addr_o     <= bank_i ? LD_B1 : '0;
            end else if (store_start_i) begin
              state           <= STORE;
              busy_o          <= 1'b1;
              BRAM_we_o       <= 1'b1;
              RES_reg_shift_o <= 1'b1;
              BRAM_addr_o     <= bank_i ? ST_B1 : ST_B0;
            end else begin
              busy_o          <= 1'b0;
              BRAM_we_o       <= 1'b0;
              RES_reg_shift_o <= 1'b0;
              BRAM_addr_o     <= '0;
            end
          end
          LOAD: begin
            BRAM_addr_o <= BRAM_addr_o + ADDR_ONE;
            if (cnt == LD_LAST) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DRAIN: begin
            if (cnt == DR_LAST) begin
              state       <= IDLE;
              cnt         <= '0;
              busy_o      <= 1'b0;
              BRAM_addr_o <= '0;
              load_done_o <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          STORE: begin
            BRAM_addr_o <= BRAM_addr_o + ADDR_ONE;
            if (cnt == ST_LAST) begin
              state           <= IDLE;
              cnt             <= '0;
              seg             <= '0;
              busy_o          <= 1'b0;
              BRAM_we_o       <= 1'b0;
              RES_reg_shift_o <= 1'b0;
              RES_ch_o        <= '0;
              store_done_o    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (seg == SEG_LAST) begin
                seg      <= '0;
                RES_ch_o <= RES_ch_o + 2'd1;
              end else begin
                seg <= seg + CNT_ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read-tag delay line matching the BRAM read latency. Stage LAT-1 is the
  // output register; v_in/s_in present the input of each stage so the chain
  // works for LAT=1 as well.
  logic [LAT-1:0] pv;
  logic [1:0]     ps   [LAT];
  logic [LAT-1:0] v_in;
  logic [1:0]     s_in [LAT];

  always_comb begin
    v_in[0] = load_active;
    s_in[0] = tag;
    for (int unsigned i = 1; i < LAT; i++) begin
      v_in[i] = pv[i-1];
      s_in[i] = ps[i-1];
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      pv <= '0;
      for (int unsigned i = 0; i < LAT; i++) ps[i] <= '0;
    end else if (abort_i && busy_o) begin
      pv <= '0;
    end else begin
      for (int unsigned i = 0; i < LAT; i++) pv[i] <= v_in[i];
      for (int unsigned i = 0; i + 1 < LAT; i++) ps[i] <= s_in[i];
      // Output selector holds between valid words and clears after load_done.
      if (v_in[LAT-1])     ps[LAT-1] <= s_in[LAT-1];
      else if (load_done_o) ps[LAT-1] <= '0;
    end
  end

  assign INPUT_reg_en_o  = pv[LAT-1];
  assign INPUT_reg_sel_o = ps[LAT-1];

endmodule

// File: tb/tb_poly_memory_control_mc.sv
module tb_poly_memory_control_mc;

  localparam int N      = 5;
  localparam int S      = 4;
  localparam int LAT    = 2;
  localparam int NB_CH  = 2;
  localparam int NS     = N * S;
  localparam int LD_LEN = 3 * NS + N;
  localparam int ST_LEN = NB_CH * NS;
  localparam int REGION = LD_LEN + ST_LEN;
  localparam int AW     = $clog2(2 * REGION) + 1;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          load_start_i, store_start_i, abort_i, bank_i;
  logic          BRAM_we_o;
  logic [AW-1:0] BRAM_addr_o;
  logic [1:0]    INPUT_reg_sel_o;
  logic          INPUT_reg_en_o;
  logic          RES_reg_shift_o;
  logic [1:0]    RES_ch_o;
  logic          busy_o, load_done_o, store_done_o;

  int n_vec = 0;
  int n_err = 0;

  poly_memory_control_mc #(
    .WORD_WIDTH(17), .N(N), .S(S), .LAT(LAT), .NB_CH(NB_CH)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .load_start_i   (load_start_i),
    .store_start_i  (store_start_i),
    .abort_i        (abort_i),
    .bank_i         (bank_i),
    .BRAM_we_o      (BRAM_we_o),
    .BRAM_addr_o    (BRAM_addr_o),
    .INPUT_reg_sel_o(INPUT_reg_sel_o),
    .INPUT_reg_en_o (INPUT_reg_en_o),
    .RES_reg_shift_o(RES_reg_shift_o),
    .RES_ch_o       (RES_ch_o),
    .busy_o         (busy_o),
    .load_done_o    (load_done_o),
    .store_done_o   (store_done_o)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs in cycle c of a sequence, derived from the address map:
  // load reads B0+k in cycle k and the data returns LAT cycles later; store
  // writes B0+LD_LEN+j in cycle j. After an abort everything reads as idle.
  task automatic check_cycle(input bit is_load, input bit bnk, input int c, input int abort_at);
    int  b0     = bnk ? REGION : 0;
    int  e_addr = 0;
    int  e_en   = 0;
    int  e_sel  = -1;
    int  e_we   = 0;
    int  e_ch   = 0;
    int  e_busy = 0;
    int  e_ld   = 0;
    int  e_sd   = 0;
    bit  dead   = (abort_at >= 0) && (c > abort_at);
    if (!dead) begin
      if (is_load) begin
        if (c < LD_LEN)            e_addr = b0 + c;
        else if (c < LD_LEN + LAT) e_addr = b0 + LD_LEN;
        e_en   = (c >= LAT && c < LD_LEN + LAT) ? 1 : 0;
        e_busy = (c < LD_LEN + LAT) ? 1 : 0;
        e_ld   = (c == LD_LEN + LAT) ? 1 : 0;
        if (e_en == 1) begin
          e_sel = (c - LAT) / NS;
          if (e_sel > 3) e_sel = 3;
        end else if (c > LD_LEN + LAT) begin
          e_sel = 0;
        end
      end else begin
        if (c < ST_LEN)       e_addr = b0 + LD_LEN + c;
        else if (c == ST_LEN) e_addr = b0 + REGION;
        e_we   = (c < ST_LEN) ? 1 : 0;
        e_ch   = (c < ST_LEN) ? c / NS : 0;
        e_busy = (c < ST_LEN) ? 1 : 0;
        e_sd   = (c == ST_LEN) ? 1 : 0;
      end
    end
    chk("addr",       c, 32'(BRAM_addr_o),     e_addr);
    chk("en",         c, 32'(INPUT_reg_en_o),  e_en);
    chk("we",         c, 32'(BRAM_we_o),       e_we);
    chk("shift",      c, 32'(RES_reg_shift_o), e_we);
    chk("ch",         c, 32'(RES_ch_o),        e_ch);
    chk("busy",       c, 32'(busy_o),          e_busy);
    chk("load_done",  c, 32'(load_done_o),     e_ld);
    chk("store_done", c, 32'(store_done_o),    e_sd);
    if (e_sel >= 0) chk("sel", c, 32'(INPUT_reg_sel_o), e_sel);
  endtask

  // Called at a negedge; runs one sequence with optional abort, an ignored
  // start while busy, and an optional start chained into the final cycle.
  // chain: 0 none, 1 load, 2 store.
  task automatic run_op(input bit is_load, input bit bnk, input int abort_at, input int intrude_at,
                        input bit both, input bit skip_start, input int chain, input bit chain_bank);
    int last;
    if (!skip_start) begin
      load_start_i  = is_load | both;
      store_start_i = !is_load | both;
      bank_i        = bnk;
    end
    last = (abort_at >= 0) ? abort_at + 1 : (is_load ? LD_LEN + LAT : ST_LEN);
    for (int c = 0; c <= last; c++) begin
      @(negedge clock_i);
      load_start_i  = 1'b0;
      store_start_i = 1'b0;
      abort_i       = 1'b0;
      bank_i        = 1'($urandom);
      check_cycle(is_load, bnk, c, abort_at);
      if (c == abort_at) abort_i = 1'b1;
      if (c == intrude_at) begin
        store_start_i = 1'b1;
        load_start_i  = 1'($urandom);
      end
      if (c == last && chain != 0) begin
        load_start_i  = (chain == 1);
        store_start_i = (chain == 2);
        bank_i        = chain_bank;
      end
    end
    if (chain == 0) begin
      @(negedge clock_i);
      bank_i = 1'b0;
      check_cycle(is_load, bnk, last + 1, abort_at);
    end
  endtask

  initial begin
    bit is_load, bnk, both, pend, pend_load, pend_bank, cb;
    int end_c, abort_at, lim, intr, chain;

    load_start_i  = 1'b0;
    store_start_i = 1'b0;
    abort_i       = 1'b0;
    bank_i        = 1'b0;
    reset_i       = 1'b1;
    #1 reset_i = 1'b0;
    #1;
    chk("rst_addr", -1, 32'(BRAM_addr_o), 0);
    chk("rst_busy", -1, 32'(busy_o), 0);
    chk("rst_en",   -1, 32'(INPUT_reg_en_o), 0);
    chk("rst_sel",  -1, 32'(INPUT_reg_sel_o), 0);
    repeat (2) @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    check_cycle(1'b1, 1'b0, LD_LEN + LAT + 1, -1);

    // Simultaneous starts: load wins; a store at cycle 10 is ignored.
    run_op(1'b1, 1'b0, -1, 10, 1'b1, 1'b0, 0, 1'b0);
    // Store to bank 1.
    run_op(1'b0, 1'b1, -1, -1, 1'b0, 1'b0, 0, 1'b0);
    // Abort at LOAD cycle 20, then a normal load.
    run_op(1'b1, 1'($urandom), 20, -1, 1'b0, 1'b0, 0, 1'b0);
    run_op(1'b1, 1'b1, -1, -1, 1'b0, 1'b0, 0, 1'b0);
    // Back-to-back: store issued in the load_done cycle.
    run_op(1'b1, 1'b0, -1, -1, 1'b0, 1'b0, 2, 1'b0);
    run_op(1'b0, 1'b0, -1, -1, 1'b0, 1'b1, 0, 1'b0);

    // Abort and start in the same idle cycle: start is dropped.
    abort_i = 1'b1; load_start_i = 1'b1; store_start_i = 1'b1; bank_i = 1'b1;
    @(negedge clock_i);
    abort_i = 1'b0; load_start_i = 1'b0; store_start_i = 1'b0;
    chk("abort_idle_busy", 0, 32'(busy_o), 0);
    chk("abort_idle_addr", 0, 32'(BRAM_addr_o), 0);
    chk("abort_idle_we",   0, 32'(BRAM_we_o), 0);
    @(negedge clock_i);
    chk("abort_idle_busy", 1, 32'(busy_o), 0);
    chk("abort_idle_en",   1, 32'(INPUT_reg_en_o), 0);

    // Randomized sequences.
    pend = 1'b0; pend_load = 1'b0; pend_bank = 1'b0;
    for (int i = 0; i < 16; i++) begin
      is_load  = pend ? pend_load : 1'($urandom);
      bnk      = pend ? pend_bank : 1'($urandom);
      end_c    = is_load ? LD_LEN + LAT : ST_LEN;
      abort_at = ($urandom % 3 == 0) ? int'($urandom_range(0, end_c - 1)) : -1;
      lim      = (abort_at >= 0) ? abort_at : end_c - 1;
      intr     = ($urandom % 2 == 0) ? int'($urandom_range(0, lim)) : -1;
      chain    = (i < 15 && $urandom % 4 == 0) ? 1 + int'($urandom % 2) : 0;
      cb       = 1'($urandom);
      both     = is_load & 1'($urandom);
      run_op(is_load, bnk, abort_at, intr, both, pend, chain, cb);
      pend      = (chain != 0);
      pend_load = (chain == 1);
      pend_bank = cb;
    end

    // Asynchronous reset mid-load at address 30.
    load_start_i = 1'b1; bank_i = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      @(negedge clock_i);
      load_start_i = 1'b0;
      bank_i = 1'($urandom);
    end
    chk("pre_reset_addr", 30, 32'(BRAM_addr_o), 30);
    #2 reset_i = 1'b0;
    #1;
    chk("areset_addr",  30, 32'(BRAM_addr_o), 0);
    chk("areset_busy",  30, 32'(busy_o), 0);
    chk("areset_en",    30, 32'(INPUT_reg_en_o), 0);
    chk("areset_sel",   30, 32'(INPUT_reg_sel_o), 0);
    chk("areset_we",    30, 32'(BRAM_we_o), 0);
    chk("areset_shift", 30, 32'(RES_reg_shift_o), 0);
    chk("areset_ch",    30, 32'(RES_ch_o), 0);
    chk("areset_ld",    30, 32'(load_done_o), 0);
    chk("areset_sd",    30, 32'(store_done_o), 0);
    @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    chk("post_reset_addr", 0, 32'(BRAM_addr_o), 0);
    chk("post_reset_busy", 0, 32'(busy_o), 0);
    run_op(1'b1, 1'b1, -1, -1, 1'b0, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
